// File: rtl/arcade_input_pkg.sv
// Shared scan codes, joystick bit layout, rotate encoding and keyboard decode for the arcade input mapper.
// Pure declarations; no timing or backpressure.
package arcade_input_pkg;

    localparam int JOY_RIGHT = 0;
    localparam int JOY_LEFT  = 1;
    localparam int JOY_DOWN  = 2;
    localparam int JOY_UP    = 3;
    localparam int JOY_BTN0  = 4;

    localparam logic [7:0] SC_P1_UP    = 8'h75;
    localparam logic [7:0] SC_P1_DOWN  = 8'h72;
    localparam logic [7:0] SC_P1_LEFT  = 8'h6B;
    localparam logic [7:0] SC_P1_RIGHT = 8'h74;
    localparam logic [7:0] SC_P1_B0    = 8'h14;
    localparam logic [7:0] SC_P1_B1    = 8'h11;
    localparam logic [7:0] SC_P1_B2    = 8'h29;
    localparam logic [7:0] SC_P1_B3    = 8'h12;
    localparam logic [7:0] SC_P1_START = 8'h16;
    localparam logic [7:0] SC_P1_COIN  = 8'h2E;
    localparam logic [7:0] SC_P2_UP    = 8'h2D;
    localparam logic [7:0] SC_P2_DOWN  = 8'h2B;
    localparam logic [7:0] SC_P2_LEFT  = 8'h23;
    localparam logic [7:0] SC_P2_RIGHT = 8'h34;
    localparam logic [7:0] SC_P2_B0    = 8'h1C;
    localparam logic [7:0] SC_P2_B1    = 8'h1B;
    localparam logic [7:0] SC_P2_B2    = 8'h15;
    localparam logic [7:0] SC_P2_B3    = 8'h1D;
    localparam logic [7:0] SC_P2_START = 8'h1E;
    localparam logic [7:0] SC_P2_COIN  = 8'h36;
    localparam logic [7:0] SC_P3_START = 8'h26;
    localparam logic [7:0] SC_P4_START = 8'h25;
    localparam logic [7:0] SC_P3_COIN  = 8'h3D;
    localparam logic [7:0] SC_P4_COIN  = 8'h3E;
    localparam logic [7:0] SC_SERVICE  = 8'h06;

    typedef enum logic [1:0] {
        ROT_NONE = 2'd0,
        ROT_CW   = 2'd1,
        ROT_CCW  = 2'd2,
        ROT_RSVD = 2'd3
    } rot_e;

    typedef enum logic [2:0] {K_NONE, K_DIR, K_BTN, K_START, K_COIN, K_SVC} key_kind_e;

    typedef struct packed {
        key_kind_e  kind;
        logic [1:0] player;
        logic [2:0] idx;
    } key_map_t;

    // P1 directions live on the extended (cursor) keys; every other mapping matches on code alone.
    function automatic key_map_t map_key(input logic ext, input logic [7:0] code);
        key_map_t m;
        m = '{kind: K_NONE, player: 2'd0, idx: 3'd0};
        if (ext) begin
            case (code)
                SC_P1_UP:    m = '{K_DIR, 2'd0, 3'(JOY_UP)};
                SC_P1_DOWN:  m = '{K_DIR, 2'd0, 3'(JOY_DOWN)};
                SC_P1_LEFT:  m = '{K_DIR, 2'd0, 3'(JOY_LEFT)};
                SC_P1_RIGHT: m = '{K_DIR, 2'd0, 3'(JOY_RIGHT)};
                default:     m = m;
            endcase
        end
        if (m.kind == K_NONE) begin
            case (code)
                SC_P1_B0:    m = '{K_BTN,   2'd0, 3'd0};
                SC_P1_B1:    m = '{K_BTN,   2'd0, 3'd1};
                SC_P1_B2:    m = '{K_BTN,   2'd0, 3'd2};
                SC_P1_B3:    m = '{K_BTN,   2'd0, 3'd3};
                SC_P1_START: m = '{K_START, 2'd0, 3'd0};
                SC_P1_COIN:  m = '{K_COIN,  2'd0, 3'd0};
                SC_P2_UP:    m = '{K_DIR,   2'd1, 3'(JOY_UP)};
                SC_P2_DOWN:  m = '{K_DIR,   2'd1, 3'(JOY_DOWN)};
                SC_P2_LEFT:  m = '{K_DIR,   2'd1, 3'(JOY_LEFT)};
                SC_P2_RIGHT: m = '{K_DIR,   2'd1, 3'(JOY_RIGHT)};
                SC_P2_B0:    m = '{K_BTN,   2'd1, 3'd0};
                SC_P2_B1:    m = '{K_BTN,   2'd1, 3'd1};
                SC_P2_B2:    m = '{K_BTN,   2'd1, 3'd2};
                SC_P2_B3:    m = '{K_BTN,   2'd1, 3'd3};
                SC_P2_START: m = '{K_START, 2'd1, 3'd0};
                SC_P2_COIN:  m = '{K_COIN,  2'd1, 3'd0};
                SC_P3_START: m = '{K_START, 2'd2, 3'd0};
                SC_P3_COIN:  m = '{K_COIN,  2'd2, 3'd0};
                SC_P4_START: m = '{K_START, 2'd3, 3'd0};
                SC_P4_COIN:  m = '{K_COIN,  2'd3, 3'd0};
                SC_SERVICE:  m = '{K_SVC,   2'd0, 3'd0};
                default:     m = m;
            endcase
        end
        return m;
    endfunction

endpackage

// File: rtl/arcade_input_mapper_coin_stretch.sv
// Stretches a coin press to at least COIN_FRAMES frame ticks; output registered, 1 cycle after raw.
// No backpressure; a new rising edge mid-count reloads the counter.
module coin_stretch
    import arcade_input_pkg::*;
#(
    parameter int COIN_FRAMES = 3
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic raw_i,
    input  logic tick_i,
    input  logic clear_i,
    output logic coin_o
);

    logic       raw_q, raw_d;
    logic [3:0] cnt_q, cnt_d;
    logic       coin_q, coin_d;

    always_comb begin
        raw_d = raw_i;
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (raw_i && !raw_q) begin
            cnt_d = 4'(COIN_FRAMES);
        end else if (tick_i && (cnt_q != 4'd0)) begin
            cnt_d = cnt_q - 4'd1;
        end
        coin_d = raw_i || (cnt_d != 4'd0);
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            raw_q  <= 1'b0;
            cnt_q  <= '0;
            coin_q <= 1'b0;
        end else begin
            raw_q  <= raw_d;
            cnt_q  <= cnt_d;
            coin_q <= coin_d;
        end
    end

    assign coin_o = coin_q;

endmodule

// File: rtl/arcade_input_mapper.sv
// Merges PS/2 keys and joysticks into rotated per-player controls; 1 cycle from joystick, 2 from key toggle.
// No backpressure. Define ARCADE_INPUT_AUTOFIRE_EN to add autofire_mask with a 2-tick phase gate.
module arcade_input_mapper
    import arcade_input_pkg::*;
#(
    parameter int NUM_PLAYERS = 2,
    parameter int NUM_BUTTONS = 4,
    parameter int COIN_FRAMES = 3
) (
    input  logic                               clk_sys,
    input  logic                               reset_n,
    input  logic [10:0]                        ps2_key,
    input  logic [16*NUM_PLAYERS-1:0]          joystick,
    input  logic [1:0]                         rotate,
    input  logic                               vblank,
    input  logic                               clear,
`ifdef ARCADE_INPUT_AUTOFIRE_EN
    input  logic [NUM_BUTTONS-1:0]             autofire_mask,
`endif
    output logic [4*NUM_PLAYERS-1:0]           dir_o,
    output logic [NUM_BUTTONS*NUM_PLAYERS-1:0] btn_o,
    output logic [NUM_PLAYERS-1:0]             start_o,
    output logic [NUM_PLAYERS-1:0]             coin_o,
    output logic                               service_o
);

    logic                              init_q, init_d;
    logic                              tog_q, tog_d;
    logic                              vb_q, vb_d;
    logic [16*NUM_PLAYERS-1:0]         kbd_q, kbd_d;
    logic                              svc_key_q, svc_key_d;
    logic [4*NUM_PLAYERS-1:0]          dir_q, dir_d;
    logic [NUM_BUTTONS*NUM_PLAYERS-1:0] btn_q, btn_d;
    logic [NUM_PLAYERS-1:0]            start_q, start_d;
    logic                              svc_q, svc_d;

    logic [16*NUM_PLAYERS-1:0] raw;
    logic [NUM_PLAYERS-1:0]    coin_raw;
    logic [NUM_BUTTONS-1:0]    af_gate;
    logic [3:0]                jr, jd;
    logic [4:0]                slot;
    logic                      slot_vld;
    logic                      key_evt;
    logic                      tick;
    key_map_t                  km;
    logic                      unused_raw;

`ifdef ARCADE_INPUT_AUTOFIRE_EN
    logic phase_q, phase_d, half_q, half_d;
`endif

    always_comb begin
        km      = map_key(ps2_key[8], ps2_key[7:0]);
        // init_q masks the first edge so a held toggle or vblank across reset is not an event.
        key_evt = init_q && (ps2_key[10] != tog_q);
        tick    = init_q && vblank && !vb_q;
        init_d  = 1'b1;
        tog_d   = ps2_key[10];
        vb_d    = vblank;

        slot_vld = 1'b1;
        slot     = '0;
        case (km.kind)
            K_DIR:   slot = {2'b00, km.idx};
            K_BTN: begin
                slot     = 5'd4 + {2'b00, km.idx};
                slot_vld = int'(km.idx) < NUM_BUTTONS;
            end
            K_START: slot = 5'(JOY_BTN0 + NUM_BUTTONS);
            K_COIN:  slot = 5'(JOY_BTN0 + NUM_BUTTONS + 1);
            default: slot_vld = 1'b0;
        endcase

        kbd_d     = kbd_q;
        svc_key_d = svc_key_q;
        if (clear) begin
            kbd_d     = '0;
            svc_key_d = 1'b0;
        end else if (key_evt) begin
            if (km.kind == K_SVC) svc_key_d = ps2_key[9];
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                for (int i = 0; i < 16; i++) begin
                    if (slot_vld && (int'(km.player) == p) && (int'(slot) == i))
                        kbd_d[p*16+i] = ps2_key[9];
                end
            end
        end

        raw     = kbd_q | joystick;
        af_gate = '1;
`ifdef ARCADE_INPUT_AUTOFIRE_EN
        phase_d = phase_q;
        half_d  = half_q;
        if (tick) begin
            half_d = !half_q;
            if (half_q) phase_d = !phase_q;
        end
        af_gate = ~autofire_mask | {NUM_BUTTONS{phase_q}};
`endif

        dir_d    = '0;
        btn_d    = '0;
        start_d  = '0;
        coin_raw = '0;
        jr       = '0;
        jd       = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            jr = raw[p*16 +: 4];
            case (rot_e'(rotate))
                ROT_CW:  jd = {jr[JOY_LEFT], jr[JOY_RIGHT], jr[JOY_DOWN], jr[JOY_UP]};
                ROT_CCW: jd = {jr[JOY_RIGHT], jr[JOY_LEFT], jr[JOY_UP], jr[JOY_DOWN]};
                default: jd = jr;
            endcase
            if (jd[3] && jd[2]) jd[3:2] = 2'b00;
            if (jd[1] && jd[0]) jd[1:0] = 2'b00;
            dir_d[p*4 +: 4]                     = jd;
            btn_d[p*NUM_BUTTONS +: NUM_BUTTONS] = raw[p*16+JOY_BTN0 +: NUM_BUTTONS] & af_gate;
            start_d[p]                          = raw[p*16+JOY_BTN0+NUM_BUTTONS];
            coin_raw[p]                         = raw[p*16+JOY_BTN0+NUM_BUTTONS+1];
        end
        svc_d = svc_key_q;
    end

    assign unused_raw = ^raw;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            init_q    <= 1'b0;
            tog_q     <= 1'b0;
            vb_q      <= 1'b0;
            kbd_q     <= '0;
            svc_key_q <= 1'b0;
            dir_q     <= '0;
            btn_q     <= '0;
            start_q   <= '0;
            svc_q     <= 1'b0;
        end else begin
            init_q    <= init_d;
            tog_q     <= tog_d;
            vb_q      <= vb_d;
            kbd_q     <= kbd_d;
            svc_key_q <= svc_key_d;
            dir_q     <= dir_d;
            btn_q     <= btn_d;
            start_q   <= start_d;
            svc_q     <= svc_d;
        end
    end

`ifdef ARCADE_INPUT_AUTOFIRE_EN
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            phase_q <= 1'b0;
            half_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            half_q  <= half_d;
        end
    end
`endif

    for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_coin
        coin_stretch #(.COIN_FRAMES(COIN_FRAMES)) u_coin (
            .clk_sys (clk_sys),
            .reset_n (reset_n),
            .raw_i   (coin_raw[g]),
            .tick_i  (tick),
            .clear_i (clear),
            .coin_o  (coin_o[g])
        );
    end

    assign dir_o     = dir_q;
    assign btn_o     = btn_q;
    assign start_o   = start_q;
    assign service_o = svc_q;

endmodule

// File: tb/tb_arcade_input_mapper.sv
// Randomised and directed checks of arcade_input_mapper against a behavioural model of its key, rotate and coin rules.
module tb_arcade_input_mapper;
    localparam int NP = 2;
    localparam int NB = 4;
    localparam int CF = 3;

    logic clk_sys = 1'b0;
    logic reset_n;
    logic [10:0] ps2_key;
    logic [16*NP-1:0] joystick;
    logic [1:0] rotate;
    logic vblank;
    logic clear;
`ifdef ARCADE_INPUT_AUTOFIRE_EN
    logic [NB-1:0] autofire_mask;
`endif
    logic [4*NP-1:0] dir_o;
    logic [NB*NP-1:0] btn_o;
    logic [NP-1:0] start_o;
    logic [NP-1:0] coin_o;
    logic service_o;

    int n_checks = 0;
    int n_fail = 0;

    bit m_init;
    bit m_tog;
    bit [15:0] m_kbd [NP];
    bit m_svc;
    int m_cnt [NP];
    bit m_prev [NP];
    bit m_vb;
    int m_ticks;

    logic [4*NP-1:0] exp_dir;
    logic [NB*NP-1:0] exp_btn;
    logic [NP-1:0] exp_start;
    logic [NP-1:0] exp_coin;
    logic exp_svc;

    arcade_input_mapper #(.NUM_PLAYERS(NP), .NUM_BUTTONS(NB), .COIN_FRAMES(CF)) dut (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .ps2_key   (ps2_key),
        .joystick  (joystick),
        .rotate    (rotate),
        .vblank    (vblank),
        .clear     (clear),
`ifdef ARCADE_INPUT_AUTOFIRE_EN
        .autofire_mask (autofire_mask),
`endif
        .dir_o     (dir_o),
        .btn_o     (btn_o),
        .start_o   (start_o),
        .coin_o    (coin_o),
        .service_o (service_o)
    );

    always #5 clk_sys = ~clk_sys;

    // Keymap as a flat target: player*16 + joystick-layout slot, 64 = service, -1 = unmapped.
    function automatic int key_target(bit ext, bit [7:0] code);
        if (ext) begin
            case (code)
                8'h75: return 3;
                8'h72: return 2;
                8'h6B: return 1;
                8'h74: return 0;
                default: ;
            endcase
        end
        case (code)
            8'h14: return 4;   8'h11: return 5;   8'h29: return 6;   8'h12: return 7;
            8'h16: return 8;   8'h2E: return 9;
            8'h2D: return 19;  8'h2B: return 18;  8'h23: return 17;  8'h34: return 16;
            8'h1C: return 20;  8'h1B: return 21;  8'h15: return 22;  8'h1D: return 23;
            8'h1E: return 24;  8'h36: return 25;
            8'h26: return 40;  8'h3D: return 41;  8'h25: return 56;  8'h3E: return 57;
            8'h06: return 64;
            default: return -1;
        endcase
    endfunction

    task automatic model_reset();
        m_init = 0; m_tog = 0; m_svc = 0; m_vb = 0; m_ticks = 0;
        for (int p = 0; p < NP; p++) begin
            m_kbd[p] = '0; m_cnt[p] = 0; m_prev[p] = 0;
        end
    endtask

    // Predicts the outputs after the coming edge, then advances the model past it.
    task automatic model_step();
        bit tick, u, d, l, r, nu, nd, nl, nr, rc, phase;
        bit [15:0] raw;
        bit [NB-1:0] af;
        int tgt;
        af = '0;
`ifdef ARCADE_INPUT_AUTOFIRE_EN
        af = autofire_mask;
`endif
        tick = m_init && vblank && !m_vb;
        phase = ((m_ticks / 2) % 2) == 1;
        for (int p = 0; p < NP; p++) begin
            raw = m_kbd[p] | joystick[p*16 +: 16];
            {u, d, l, r} = raw[3:0];
            case (rotate)
                2'd1:    {nu, nd, nl, nr} = {l, r, d, u};
                2'd2:    {nu, nd, nl, nr} = {r, l, u, d};
                default: {nu, nd, nl, nr} = {u, d, l, r};
            endcase
            if (nu && nd) {nu, nd} = 2'b00;
            if (nl && nr) {nl, nr} = 2'b00;
            exp_dir[p*4 +: 4] = {nu, nd, nl, nr};
            for (int b = 0; b < NB; b++) exp_btn[p*NB+b] = raw[4+b] && (!af[b] || phase);
            exp_start[p] = raw[4+NB];
            rc = raw[5+NB];
            if (clear) m_cnt[p] = 0;
            else if (rc && !m_prev[p]) m_cnt[p] = CF;
            else if (tick && m_cnt[p] > 0) m_cnt[p] = m_cnt[p] - 1;
            m_prev[p] = rc;
            exp_coin[p] = rc || (m_cnt[p] != 0);
        end
        exp_svc = m_svc;
        if (m_init && (ps2_key[10] != m_tog) && !clear) begin
            tgt = key_target(ps2_key[8], ps2_key[7:0]);
            if (tgt == 64) m_svc = ps2_key[9];
            else if (tgt >= 0 && tgt < 16*NP) m_kbd[tgt/16][tgt%16] = ps2_key[9];
        end
        if (clear) begin
            m_svc = 0;
            for (int p = 0; p < NP; p++) m_kbd[p] = '0;
        end
        m_tog = ps2_key[10];
        m_init = 1;
        if (tick) m_ticks++;
        m_vb = vblank;
    endtask

    task automatic step();
        model_step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 0; ps2_key = {1'b1, 1'b1, 1'b1, 8'h75}; joystick = '0;
        rotate = 2'd0; vblank = 1; clear = 0;
`ifdef ARCADE_INPUT_AUTOFIRE_EN
        autofire_mask = '0;
`endif
        repeat (3) @(posedge clk_sys);
        #1;
        n_checks++; if (dir_o !== '0) begin n_fail++; $display("FAIL rst_dir: got %h exp 0", dir_o); end
        n_checks++; if (btn_o !== '0) begin n_fail++; $display("FAIL rst_btn: got %h exp 0", btn_o); end
        n_checks++; if (start_o !== '0) begin n_fail++; $display("FAIL rst_start: got %h exp 0", start_o); end
        n_checks++; if (coin_o !== '0) begin n_fail++; $display("FAIL rst_coin: got %h exp 0", coin_o); end
        n_checks++; if (service_o !== 1'b0) begin n_fail++; $display("FAIL rst_svc: got %b exp 0", service_o); end
        model_reset();
        reset_n = 1;
        repeat (3) step();
        n_checks++; if (dir_o !== '0) begin n_fail++; $display("FAIL rst_toggle_held: got %h exp 0", dir_o); end
        vblank = 0;
        step();
    endtask

    task automatic test_key_event();
        ps2_key = {1'b0, 1'b0, 1'b1, 8'h75}; step(); step();
        ps2_key = {1'b1, 1'b1, 1'b1, 8'h75}; step();
        n_checks++; if (dir_o[3] !== 1'b0) begin n_fail++; $display("FAIL key_lat1: got %b exp 0", dir_o[3]); end
        step();
        n_checks++; if (dir_o[3] !== 1'b1) begin n_fail++; $display("FAIL key_press: got %b exp 1", dir_o[3]); end
        n_checks++; if (dir_o !== exp_dir) begin n_fail++; $display("FAIL key_dir: got %h exp %h", dir_o, exp_dir); end
        ps2_key = {1'b0, 1'b0, 1'b1, 8'h75}; step(); step();
        n_checks++; if (dir_o[3] !== 1'b0) begin n_fail++; $display("FAIL key_release: got %b exp 0", dir_o[3]); end
        ps2_key = {1'b1, 1'b1, 1'b0, 8'h06}; step(); step();
        n_checks++; if (service_o !== 1'b1) begin n_fail++; $display("FAIL key_service: got %b exp 1", service_o); end
        ps2_key = {1'b0, 1'b0, 1'b0, 8'h06}; step(); step();
        n_checks++; if (service_o !== 1'b0) begin n_fail++; $display("FAIL key_service_rel: got %b exp 0", service_o); end
    endtask

    task automatic test_rotate();
        logic [1:0] rv [6] = '{2'd1, 2'd1, 2'd0, 2'd2, 2'd3, 2'd1};
        logic [3:0] jv [6] = '{4'b0010, 4'b0011, 4'b1100, 4'b0010, 4'b0010, 4'b1000};
        logic [3:0] ev [6] = '{4'b1000, 4'b0000, 4'b0000, 4'b0100, 4'b0010, 4'b0001};
        for (int i = 0; i < 6; i++) begin
            rotate = rv[i];
            joystick = '0;
            joystick[3:0] = jv[i];
            step();
            n_checks++;
            if (dir_o[3:0] !== ev[i]) begin
                n_fail++; $display("FAIL rotate_%0d: got %b exp %b", i, dir_o[3:0], ev[i]);
            end
        end
        rotate = 2'd0; joystick = '0; step();
    endtask

    task automatic test_coin();
        ps2_key = {~ps2_key[10], 1'b1, 1'b0, 8'h2E}; step();
        ps2_key = {~ps2_key[10], 1'b0, 1'b0, 8'h2E}; step();
        n_checks++; if (coin_o[0] !== 1'b1) begin n_fail++; $display("FAIL coin_start: got %b exp 1", coin_o[0]); end
        step(); step();
        n_checks++; if (coin_o[0] !== 1'b1) begin n_fail++; $display("FAIL coin_hold: got %b exp 1", coin_o[0]); end
        for (int t = 1; t <= 3; t++) begin
            vblank = 1; step();
            n_checks++;
            if (coin_o[0] !== (t < 3)) begin n_fail++; $display("FAIL coin_tick%0d: got %b exp %b", t, coin_o[0], t < 3); end
            vblank = 0; step(); step();
            n_checks++;
            if (coin_o !== exp_coin) begin n_fail++; $display("FAIL coin_after%0d: got %b exp %b", t, coin_o, exp_coin); end
        end
    endtask

    task automatic test_clear();
        ps2_key = {~ps2_key[10], 1'b1, 1'b0, 8'h2D}; step(); step();
        n_checks++; if (dir_o[7] !== 1'b1) begin n_fail++; $display("FAIL clr_pre: got %b exp 1", dir_o[7]); end
        clear = 1; ps2_key = {~ps2_key[10], 1'b1, 1'b0, 8'h1C}; step();
        clear = 0; step();
        n_checks++; if (dir_o[7] !== 1'b0) begin n_fail++; $display("FAIL clr_dir: got %b exp 0", dir_o[7]); end
        n_checks++; if (btn_o[4] !== 1'b0) begin n_fail++; $display("FAIL clr_evt: got %b exp 0", btn_o[4]); end
        step();
        n_checks++; if (btn_o[4] !== 1'b0) begin n_fail++; $display("FAIL clr_track: got %b exp 0", btn_o[4]); end
        ps2_key = {~ps2_key[10], 1'b1, 1'b0, 8'h1C}; step(); step();
        n_checks++; if (btn_o[4] !== 1'b1) begin n_fail++; $display("FAIL clr_after: got %b exp 1", btn_o[4]); end
        ps2_key = {~ps2_key[10], 1'b0, 1'b0, 8'h1C}; step();
    endtask

    task automatic test_random();
        bit [7:0] codes [25] = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h14, 8'h11, 8'h29, 8'h12, 8'h16,
                                 8'h2E, 8'h2D, 8'h2B, 8'h23, 8'h34, 8'h1C, 8'h1B, 8'h15, 8'h1D,
                                 8'h1E, 8'h36, 8'h26, 8'h25, 8'h3D, 8'h3E, 8'h06};
        bit [7:0] code;
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 2) == 0) begin
                code = ($urandom_range(0, 9) == 0) ? 8'($urandom) : codes[$urandom_range(0, 24)];
                ps2_key = {~ps2_key[10], 1'($urandom), 1'($urandom), code};
            end
            if ($urandom_range(0, 3) == 0) joystick = 32'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 7) == 0) rotate = 2'($urandom);
            if ($urandom_range(0, 3) == 0) vblank = ~vblank;
`ifdef ARCADE_INPUT_AUTOFIRE_EN
            if ($urandom_range(0, 31) == 0) autofire_mask = NB'($urandom);
`endif
            clear = ($urandom_range(0, 49) == 0);
            step();
            n_checks++; if (dir_o !== exp_dir) begin n_fail++; $display("FAIL rnd_dir@%0d: got %h exp %h", c, dir_o, exp_dir); end
            n_checks++; if (btn_o !== exp_btn) begin n_fail++; $display("FAIL rnd_btn@%0d: got %h exp %h", c, btn_o, exp_btn); end
            n_checks++; if (start_o !== exp_start) begin n_fail++; $display("FAIL rnd_start@%0d: got %b exp %b", c, start_o, exp_start); end
            n_checks++; if (coin_o !== exp_coin) begin n_fail++; $display("FAIL rnd_coin@%0d: got %b exp %b", c, coin_o, exp_coin); end
            n_checks++; if (service_o !== exp_svc) begin n_fail++; $display("FAIL rnd_svc@%0d: got %b exp %b", c, service_o, exp_svc); end
        end
        clear = 0;
    endtask

`ifdef ARCADE_INPUT_AUTOFIRE_EN
    task automatic test_autofire();
        int flips;
        logic last;
        clear = 1; step(); clear = 0;
        joystick = '0; joystick[4] = 1'b1; joystick[5] = 1'b1;
        autofire_mask = 4'b0001; vblank = 0;
        step();
        last = btn_o[0];
        flips = 0;
        for (int f = 0; f < 8; f++) begin
            vblank = 1; step(); vblank = 0;
            for (int k = 0; k < 4; k++) begin
                n_checks++; if (btn_o[0] !== exp_btn[0]) begin n_fail++; $display("FAIL af_b0: got %b exp %b", btn_o[0], exp_btn[0]); end
                n_checks++; if (btn_o[1] !== 1'b1) begin n_fail++; $display("FAIL af_b1: got %b exp 1", btn_o[1]); end
                if (btn_o[0] !== last) flips++;
                last = btn_o[0];
                if (k < 3) step();
            end
        end
        n_checks++; if (flips != 4) begin n_fail++; $display("FAIL af_flips: got %0d exp 4", flips); end
        autofire_mask = '0; joystick = '0; step();
    endtask
`endif

    initial begin
        test_reset();
        test_key_event();
        test_rotate();
        test_coin();
        test_clear();
        test_random();
`ifdef ARCADE_INPUT_AUTOFIRE_EN
        test_autofire();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/arcade_input_mapper.md
ARCADE_INPUT_MAPPER -- requirements
Module: arcade_input_mapper

Interface
REQ-001 Parameter NUM_PLAYERS, default 2: player count, legal 1..4.
REQ-002 Parameter NUM_BUTTONS, default 4: action buttons per player, legal 1..8.
REQ-003 Parameter COIN_FRAMES, default 3: minimum coin pulse length in frames, legal 1..15.
REQ-004 clk_sys  in  1  single system clock; all logic on its rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 ps2_key  in  11  [10] event toggle, [9] pressed, [8] extended, [7:0] scan code.
REQ-007 joystick  in  16*NUM_PLAYERS  per player: [0] right, [1] left, [2] down, [3] up, [4+b] button b, [4+NUM_BUTTONS] start, [5+NUM_BUTTONS] coin.
REQ-008 rotate  in  2  0 none, 1 clockwise, 2 counter-clockwise, 3 treated as 0.
REQ-009 vblank  in  1  frame timing; rising edge = frame tick.
REQ-010 clear  in  1  synchronous clear of keyboard state and coin counters.
REQ-011 dir_o  out  4*NUM_PLAYERS  per player {up,down,left,right}, active-high.
REQ-012 btn_o  out  NUM_BUTTONS*NUM_PLAYERS  action buttons, active-high.
REQ-013 start_o, coin_o  out  NUM_PLAYERS each  start and stretched coin, active-high.
REQ-014 service_o  out  1  service/test key, active-high.

Function
REQ-015 Key event: ps2_key[10] differs from stored toggle -> stored toggle updated, mapped key state set to ps2_key[9] on that edge; unmapped codes ignored.
REQ-016 Keymap: P1 extended 75/72/6B/74 = up/down/left/right, buttons 14,11,29,12, start 16, coin 2E; P2 2D/2B/23/34, buttons 1C,1B,15,1D, start 1E, coin 36; P3/P4 start 26/25, coin 3D/3E only; service 06 (F2); buttons >= NUM_BUTTONS ignored.
REQ-017 Raw player input = keyboard state OR joystick bits.
REQ-018 rotate=1: up<-left, down<-right, left<-down, right<-up; rotate=2: up<-right, down<-left, left<-up, right<-down.
REQ-019 After rotation, up+down both set -> both 0; left+right both set -> both 0.
REQ-020 All outputs registered: joystick/rotate change visible 1 cycle later; key event visible 2 cycles after toggle change.
REQ-021 Coin: raw rising edge loads counter with COIN_FRAMES and asserts coin_o; each frame tick decrements non-zero counter; coin_o = raw OR counter!=0; new rising edge during count reloads.
REQ-022 clear high: key state and counters zeroed next edge, wins over same-cycle key event; stored toggle still tracks ps2_key[10].
REQ-023 Frame tick from registered vblank edge detect; vblank high across reset does not generate a tick.

Reset
REQ-024 reset_n low: all outputs 0, key state 0, coin counters 0, autofire phase 0.
REQ-025 First edge after reset_n release captures ps2_key[10] into stored toggle without generating an event.

Configuration
REQ-026 ARCADE_INPUT_AUTOFIRE_EN defined: adds input autofire_mask [NUM_BUTTONS]; masked held buttons output held AND shared phase bit toggling every 2 frame ticks.
REQ-027 ARCADE_INPUT_AUTOFIRE_EN undefined: autofire_mask port and phase logic absent, buttons pass through per REQ-017/020.

Structure
REQ-028 Package arcade_input_pkg holds scan-code constants, joystick bit indices, rotate encoding enum.
REQ-029 Sub-module coin_stretch (edge detect, counter, output) instantiated NUM_PLAYERS times.

Verification
REQ-030 Toggle 0->1, pressed=1, ext=1, code 75 -> dir_o[P1 up]=1 two cycles later; release event -> 0.
REQ-031 rotate=1, joystick P1 left=1 -> dir_o P1 up=1, left=0 after 1 cycle; up+down both held -> both 0.
REQ-032 COIN_FRAMES=3, 1-cycle coin press key 2E -> coin_o[0] high until 3rd frame tick, then low.
REQ-033 ps2_key[10]=1 held through reset release -> no key state change; clear asserted with simultaneous event -> state stays 0.
REQ-034 AUTOFIRE_EN, mask=0001, button 0 held 8 frames -> btn_o[0] toggles every 2 frame ticks; button 1 held steady.
